pfpu_fcmp_pipe: RTL
===================

Name: pfpu_fcmp_pipe

Overview:
- Parametrised, pipelined successor to the combinational single-precision FPU comparator.
- Accepts raw IEEE-754 operands of configurable exponent and fraction width, and unpacks and classifies them internally.
- Evaluates ordered or unordered EQ/NE/GT/GE/LT/LE over a 2-stage valid/ready pipeline, and maintains sticky exception flags.
- Sits beside the add/sub and mul/div units under the FPU top and is shared by the single- and double-precision datapaths.

Parameters:
- EXP_W, 8, exponent field width
- FRAC_W, 23, stored fraction width (no hidden bit)
- TAG_W, 4, width of the opaque tag carried alongside each operation

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous pipeline kill
- in_valid_i  in  1  operation offered
- in_ready_o  out  1  stage 1 can accept
- opc_i  in  3  0=EQ 1=NE 2=GT 3=GE 4=LT 5=LE; 6,7 reserved
- unordered_i  in  1  unordered variant: flag=1 if either operand is NaN
- tag_i  in  TAG_W  opaque tag
- opa_i  in  1+EXP_W+FRAC_W  operand a, raw IEEE format
- opb_i  in  1+EXP_W+FRAC_W  operand b, raw IEEE format
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts
- cmp_flag_o  out  1  comparison result
- inv_o  out  1  invalid exception for this operation
- inf_o  out  1  either operand is infinity
- tag_o  out  TAG_W  tag returned with the result
- sticky_inv_o  out  1  OR of all inv_o handshaked since the last clear
- sticky_clr_i  in  1  clear the sticky flag

Behaviour:
- Reset: every valid bit, out_valid_o, cmp_flag_o, inv_o, inf_o, tag_o and sticky_inv_o are 0. Reset is asserted asynchronously and released synchronously to clk.
- Classification:
  - exp all-ones with frac != 0 is a NaN; the fraction MSB = 1 marks a qNaN, otherwise an sNaN.
  - exp all-ones with frac = 0 is infinity.
  - exp = 0 with frac = 0 is zero; +0 equals -0.
  - Denormals are compared by raw magnitude; there is no flush-to-zero.
- Stage 1 (on an in_valid_i & in_ready_o handshake) registers:
  - opc, unordered and tag
  - qnan/snan/inf/zero flags for each operand and both signs
  - mag_gt = {exp,frac}a > {exp,frac}b and mag_eq, each a single (EXP_W+FRAC_W)-bit unsigned compare
- Stage 2 registers the outputs.
- Ordering rules:
  - Any NaN: blta, altb and aeqb are all 0.
  - Both operands zero: aeqb.
  - Signs differ: the negative operand is smaller.
  - Signs equal and positive: use the magnitude result directly.
  - Signs equal and negative: use the magnitude result inverted.
  - Infinities need no special case; they order correctly by magnitude.
- Flag generation:
  - EQ=aeqb, NE=~aeqb, GT=blta, GE=blta|aeqb, LT=altb, LE=altb|aeqb.
  - Final flag = (unordered_i & anyNaN) | that result.
  - Reserved opcodes give flag=0, inv=0.
- Invalid (inv) is set when:
  - the op is EQ/NE and an sNaN is present; or
  - the op is GT/GE/LT/LE, ordered, and any NaN is present.
- Latency and handshake:
  - Latency is exactly 2 cycles from the input handshake to out_valid_o when unstalled; throughput is 1 operation per cycle.
  - A stage advances when its successor is empty or advancing.
  - in_ready_o = ~s1_valid | s2_advance, where s2_advance = ~out_valid_o | out_ready_i.
  - in_ready_o is combinational from out_ready_i.
  - Outputs hold stable while out_valid_o & ~out_ready_i.
- flush_i:
  - Clears both valid bits on the next edge.
  - An input offered in the same cycle is dropped, even though in_ready_o is high.
  - Flush has priority over advance.
- Sticky flag:
  - Set on an output handshake carrying inv_o = 1.
  - sticky_clr_i clears it.
  - If the clear and a setting handshake occur in the same cycle, the set wins (sticky_inv_o = 1 afterwards).

Optional Feature:
- Macro: PFPU_FCMP_MINMAX_EN.
- With the macro defined:
  - opc 6 = MIN and opc 7 = MAX, following IEEE-754-2008 minNum/maxNum.
  - The added output res_o (1+EXP_W+FRAC_W) returns the selected operand.
  - If exactly one operand is a qNaN, the other operand is returned. If both are NaN, the canonical qNaN (sign 0, exp all-ones, frac MSB only) is returned.
  - MIN(+0,-0) returns -0; MAX(+0,-0) returns +0.
  - Any sNaN sets inv_o.
  - cmp_flag_o = 0 for these opcodes.
  - Stage 1 also registers both raw operands.
- Without the macro: opcodes 6 and 7 are reserved and res_o is absent.

Decomposition:
- Package pfpu_pkg holds:
  - the cmp_opc_e enum (EQ..LE, MIN, MAX)
  - a fp_class_t struct {sign, qnan, snan, inf, zero}
  - a canonical-qNaN constant function parametrised by EXP_W and FRAC_W
- Sub-module pfpu_fclass: combinational unpack/classify of one operand, instantiated twice in stage 1.

Test Plan:
- 0x3F800000 LT 0x40000000 (1.0 < 2.0) -> after 2 cycles, flag=1, inv=0, inf=0.
- 0x80000000 EQ 0x00000000 (-0 == +0) -> flag=1; same operands with GT -> flag=0.
- 0x7FA00000 (sNaN) EQ 1.0 -> flag=0, inv=1, sticky_inv_o=1. Then 0x7FC00000 (qNaN) LT 1.0 with unordered=1 -> flag=1, inv=0.
- EXP_W=11, FRAC_W=52: 0xFFF0000000000000 (-inf) LT 0xC000000000000000 (-2.0) -> flag=1, inf=1.
- Back-to-back stream of 4 ops with out_ready_i held low 3 cycles -> in_ready_o drops after 2 accepts, no loss or reordering, tags 0..3 return in order. Assert flush_i mid-stream -> out_valid_o=0 the next cycle.
- MINMAX build: MIN(qNaN, 3.0) -> res_o=0x40400000; MAX(+0,-0) -> 0x00000000; MIN(sNaN, 1.0) -> inv=1.

Source files
------------

// File: rtl/pfpu_pkg.sv
// Shared types for the FPU comparator pipeline.
//   cmp_opc_e      : comparator opcodes (MIN/MAX only meaningful with
//                    PFPU_FCMP_MINMAX_EN defined)
//   fp_class_t     : per-operand classification produced by pfpu_fclass
//   canonical_qnan : canonical quiet NaN (sign 0, exp all-ones, frac MSB
//                    only) for a given exponent/fraction width, right-aligned
//                    in a FP_W_MAX-bit vector
package pfpu_pkg;

    localparam int FP_W_MAX = 128;

    typedef enum logic [2:0] {
        OPC_EQ  = 3'd0,
        OPC_NE  = 3'd1,
        OPC_GT  = 3'd2,
        OPC_GE  = 3'd3,
        OPC_LT  = 3'd4,
        OPC_LE  = 3'd5,
        OPC_MIN = 3'd6,
        OPC_MAX = 3'd7
    } cmp_opc_e;

    typedef struct packed {
        logic sign;
        logic qnan;
        logic snan;
        logic inf;
        logic zero;
    } fp_class_t;

    function automatic logic [FP_W_MAX-1:0] canonical_qnan(input int exp_w, input int frac_w);
        logic [FP_W_MAX-1:0] one;
        one = FP_W_MAX'(1);
        return (((one << exp_w) - one) << frac_w) | (one << (frac_w - 1));
    endfunction

endpackage

// File: rtl/pfpu_fcmp_pipe_if.sv
// Handshake/data bundle between the FPU top and the comparator pipeline.
// Macro: PFPU_FCMP_MINMAX_EN adds res_o (selected operand for MIN/MAX).
//   master : issuing side (drives operation, out_ready_i)
//   slave  : comparator (drives in_ready_o and the result fields)
interface pfpu_fcmp_pipe_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int TAG_W  = 4
) ();
    localparam int FP_W = 1 + EXP_W + FRAC_W;

    logic             in_valid_i;
    logic             in_ready_o;
    logic [2:0]       opc_i;
    logic             unordered_i;
    logic [TAG_W-1:0] tag_i;
    logic [FP_W-1:0]  opa_i;
    logic [FP_W-1:0]  opb_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             cmp_flag_o;
    logic             inv_o;
    logic             inf_o;
    logic [TAG_W-1:0] tag_o;
`ifdef PFPU_FCMP_MINMAX_EN
    logic [FP_W-1:0]  res_o;
`endif

    modport master (
        output in_valid_i, opc_i, unordered_i, tag_i, opa_i, opb_i, out_ready_i,
        input  in_ready_o, out_valid_o, cmp_flag_o, inv_o, inf_o, tag_o
`ifdef PFPU_FCMP_MINMAX_EN
        , input res_o
`endif
    );

    modport slave (
        input  in_valid_i, opc_i, unordered_i, tag_i, opa_i, opb_i, out_ready_i,
        output in_ready_o, out_valid_o, cmp_flag_o, inv_o, inf_o, tag_o
`ifdef PFPU_FCMP_MINMAX_EN
        , output res_o
`endif
    );

endinterface

// File: rtl/pfpu_fclass.sv
// Combinational unpack/classify of one raw IEEE-754 operand.
//   op_i  : raw operand {sign, exp, frac}
//   cls_o : sign and qnan/snan/inf/zero flags (denormals are not flagged)
module pfpu_fclass
    import pfpu_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic [EXP_W+FRAC_W:0] op_i,
    output fp_class_t             cls_o
);
    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac_f;
    logic              exp_ones;
    logic              frac_zero;

    assign exp_f     = op_i[EXP_W+FRAC_W-1:FRAC_W];
    assign frac_f    = op_i[FRAC_W-1:0];
    assign exp_ones  = &exp_f;
    assign frac_zero = ~|frac_f;

    assign cls_o.sign = op_i[EXP_W+FRAC_W];
    assign cls_o.qnan = exp_ones & frac_f[FRAC_W-1];
    assign cls_o.snan = exp_ones & ~frac_zero & ~frac_f[FRAC_W-1];
    assign cls_o.inf  = exp_ones & frac_zero;
    assign cls_o.zero = ~|exp_f & frac_zero;

endmodule

// File: rtl/pfpu_fcmp_pipe.sv
// Two-stage pipelined IEEE-754 comparator with sticky invalid flag.
// Stage 1 classifies operands and does one unsigned magnitude compare;
// stage 2 resolves sign/NaN ordering and registers the results.
// Macro: PFPU_FCMP_MINMAX_EN enables opc 6/7 = MIN/MAX (minNum/maxNum)
// and the res_o field on the bus.
//   clk, rst_n    : clock, async active-low reset (released synchronously)
//   flush_i       : kills both stages on the next edge, drops same-cycle input
//   sticky_clr_i  : clears sticky_inv_o (a same-cycle setting handshake wins)
//   sticky_inv_o  : OR of inv_o over output handshakes since last clear
//   bus           : operation/result handshake (slave modport)
module pfpu_fcmp_pipe
    import pfpu_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int TAG_W  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            sticky_clr_i,
    output logic            sticky_inv_o,
    pfpu_fcmp_pipe_if.slave bus
);
    localparam int FP_W  = 1 + EXP_W + FRAC_W;
    localparam int MAG_W = EXP_W + FRAC_W;

    logic [1:0] rst_sync;
    logic       rst_int_n;

    // Assert asynchronously, release on clk so every stage leaves reset together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    fp_class_t cls_a, cls_b;

    pfpu_fclass #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_a (.op_i(bus.opa_i), .cls_o(cls_a));
    pfpu_fclass #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_b (.op_i(bus.opb_i), .cls_o(cls_b));

    logic             s1_valid;
    cmp_opc_e         s1_opc;
    logic             s1_unord;
    logic [TAG_W-1:0] s1_tag;
    fp_class_t        s1_cls_a, s1_cls_b;
    logic             s1_mag_gt, s1_mag_eq;
`ifdef PFPU_FCMP_MINMAX_EN
    localparam logic [FP_W-1:0] CQNAN = FP_W'(canonical_qnan(EXP_W, FRAC_W));
    logic [FP_W-1:0]  s1_opa, s1_opb;
    logic [FP_W-1:0]  res_d;
    logic             nan_a, nan_b, pick_a;
`endif

    logic s2_advance, in_fire;

    assign s2_advance     = ~bus.out_valid_o | bus.out_ready_i;
    assign bus.in_ready_o = ~s1_valid | s2_advance;
    assign in_fire        = bus.in_valid_i & bus.in_ready_o;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            s1_valid  <= 1'b0;
            s1_opc    <= OPC_EQ;
            s1_unord  <= 1'b0;
            s1_tag    <= '0;
            s1_cls_a  <= '0;
            s1_cls_b  <= '0;
            s1_mag_gt <= 1'b0;
            s1_mag_eq <= 1'b0;
`ifdef PFPU_FCMP_MINMAX_EN
            s1_opa    <= '0;
            s1_opb    <= '0;
`endif
        end else begin
            if (flush_i)             s1_valid <= 1'b0;
            else if (bus.in_ready_o) s1_valid <= bus.in_valid_i;
            if (in_fire) begin
                s1_opc    <= cmp_opc_e'(bus.opc_i);
                s1_unord  <= bus.unordered_i;
                s1_tag    <= bus.tag_i;
                s1_cls_a  <= cls_a;
                s1_cls_b  <= cls_b;
                s1_mag_gt <= bus.opa_i[MAG_W-1:0] > bus.opb_i[MAG_W-1:0];
                s1_mag_eq <= bus.opa_i[MAG_W-1:0] == bus.opb_i[MAG_W-1:0];
`ifdef PFPU_FCMP_MINMAX_EN
                s1_opa    <= bus.opa_i;
                s1_opb    <= bus.opb_i;
`endif
            end
        end
    end

    logic any_nan, any_snan, both_zero, unord_hit;
    logic aeqb, altb, blta;
    logic flag_d, inv_d;

    always_comb begin
        any_snan  = s1_cls_a.snan | s1_cls_b.snan;
        any_nan   = any_snan | s1_cls_a.qnan | s1_cls_b.qnan;
        both_zero = s1_cls_a.zero & s1_cls_b.zero;
        unord_hit = s1_unord & any_nan;
        aeqb = 1'b0;
        altb = 1'b0;
        blta = 1'b0;
        if (!any_nan) begin
            if (both_zero) begin
                aeqb = 1'b1;
            end else if (s1_cls_a.sign != s1_cls_b.sign) begin
                altb = s1_cls_a.sign;
                blta = s1_cls_b.sign;
            end else if (!s1_cls_a.sign) begin
                aeqb = s1_mag_eq;
                blta = s1_mag_gt;
                altb = ~s1_mag_gt & ~s1_mag_eq;
            end else begin
                // Both negative: larger magnitude is the smaller value.
                aeqb = s1_mag_eq;
                altb = s1_mag_gt;
                blta = ~s1_mag_gt & ~s1_mag_eq;
            end
        end

        flag_d = 1'b0;
        inv_d  = 1'b0;
        case (s1_opc)
            OPC_EQ: begin flag_d = unord_hit | aeqb;         inv_d = any_snan; end
            OPC_NE: begin flag_d = unord_hit | ~aeqb;        inv_d = any_snan; end
            OPC_GT: begin flag_d = unord_hit | blta;         inv_d = ~s1_unord & any_nan; end
            OPC_GE: begin flag_d = unord_hit | blta | aeqb;  inv_d = ~s1_unord & any_nan; end
            OPC_LT: begin flag_d = unord_hit | altb;         inv_d = ~s1_unord & any_nan; end
            OPC_LE: begin flag_d = unord_hit | altb | aeqb;  inv_d = ~s1_unord & any_nan; end
`ifdef PFPU_FCMP_MINMAX_EN
            OPC_MIN, OPC_MAX: inv_d = any_snan;
`endif
            default: ;
        endcase

`ifdef PFPU_FCMP_MINMAX_EN
        nan_a = s1_cls_a.qnan | s1_cls_a.snan;
        nan_b = s1_cls_b.qnan | s1_cls_b.snan;
        // On equality the sign breaks the +0/-0 tie; otherwise either operand is identical.
        if (s1_opc == OPC_MIN) pick_a = altb | (aeqb & (~both_zero | s1_cls_a.sign));
        else                   pick_a = blta | (aeqb & (~both_zero | ~s1_cls_a.sign));
        res_d = '0;
        if (s1_opc == OPC_MIN || s1_opc == OPC_MAX) begin
            if (nan_a & nan_b) res_d = CQNAN;
            else if (nan_a)    res_d = s1_opb;
            else if (nan_b)    res_d = s1_opa;
            else               res_d = pick_a ? s1_opa : s1_opb;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            bus.out_valid_o <= 1'b0;
            bus.cmp_flag_o  <= 1'b0;
            bus.inv_o       <= 1'b0;
            bus.inf_o       <= 1'b0;
            bus.tag_o       <= '0;
`ifdef PFPU_FCMP_MINMAX_EN
            bus.res_o       <= '0;
`endif
        end else begin
            if (flush_i)         bus.out_valid_o <= 1'b0;
            else if (s2_advance) bus.out_valid_o <= s1_valid;
            if (s2_advance & s1_valid & ~flush_i) begin
                bus.cmp_flag_o <= flag_d;
                bus.inv_o      <= inv_d;
                bus.inf_o      <= s1_cls_a.inf | s1_cls_b.inf;
                bus.tag_o      <= s1_tag;
`ifdef PFPU_FCMP_MINMAX_EN
                bus.res_o      <= res_d;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n)                                        sticky_inv_o <= 1'b0;
        else if (bus.out_valid_o & bus.out_ready_i & bus.inv_o) sticky_inv_o <= 1'b1;
        else if (sticky_clr_i)                                  sticky_inv_o <= 1'b0;
    end

endmodule
